nibble_packer_4to16: RTL and testbench

- Single-clock width up-converter, the reverse of the 16-to-4 unpacking path.
- Collects a stream of 4-bit nibbles and emits packed 16-bit words through a valid/ready handshake.
- Flush support emits a partial word with a per-nibble valid mask.
- Sits on the narrow-side link ahead of wide-datapath logic. Any clock crossing is done elsewhere.

---
 rtl/nibble_packer_4to16_pkg.sv | 32 +++
 rtl/nibble_packer_4to16_pack_out_buf.sv | 59 +++++
 rtl/nibble_packer_4to16.sv | 114 +++++++++++
 tb/tb_nibble_packer_4to16.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/nibble_packer_4to16_pkg.sv
// Shared definitions for the 4-to-16 nibble packer.
// Holds the symbol/word geometry, the mask and packed word types used for
// buffer entries, and the slot-index function that maps the fill count to
// the slot a symbol lands in.
package nibble_packer_4to16_pkg;

  localparam int DATA_IN_WIDTH  = 4;
  localparam int RATIO          = 4;
  localparam int DATA_OUT_WIDTH = DATA_IN_WIDTH * RATIO;
  localparam int CNT_WIDTH      = $clog2(RATIO);
  localparam int BUF_DEPTH      = 2;

  typedef logic [RATIO-1:0]     mask_t;
  typedef logic [CNT_WIDTH-1:0] slot_t;

  // One buffer entry: the packed word plus which of its slots carry data.
  typedef struct packed {
    logic [DATA_OUT_WIDTH-1:0] data;
    mask_t                     mask;
  } word_t;

  localparam int WORD_WIDTH = $bits(word_t);

  // Slot a symbol goes to, given how many symbols the current word already
  // holds. MSB-first order fills from the top slot downwards.
  function automatic slot_t slot_index(input logic msb_first, input slot_t count);
    slot_t last;
    last = slot_t'(RATIO - 1);
    return msb_first ? (last - count) : count;
  endfunction

endpackage

// File: rtl/nibble_packer_4to16_pack_out_buf.sv
// Two-entry synchronous FIFO holding completed words for the packer.
// Ports:
//   clk       - rising-edge clock
//   rstn      - synchronous active-low reset, empties the FIFO
//   push      - write push_data at the tail (ignored when full)
//   push_data - entry to write
//   pop       - drop the head entry (ignored when empty)
//   head      - oldest entry, zero after reset
//   cnt       - number of stored entries, 0..2
module pack_out_buf #(
  parameter int WIDTH = 20
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [1:0]       cnt
);

  logic [WIDTH-1:0] mem [2];
  logic             wr_ptr;
  logic             rd_ptr;
  logic             do_push;
  logic             do_pop;

  // Guard both ends so a misbehaving caller can never corrupt the count.
  assign do_pop  = pop && (cnt != 2'd0);
  assign do_push = push && (cnt != 2'd2);

  assign head = mem[rd_ptr];

  // Storage, pointers and occupancy. A simultaneous push and pop leaves the
  // count alone while both pointers advance, so order is preserved.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      mem[0] <= '0;
      mem[1] <= '0;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      cnt    <= 2'd0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= ~wr_ptr;
      end
      if (do_pop) begin
        rd_ptr <= ~rd_ptr;
      end
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 2'd1;
        2'b01:   cnt <= cnt - 2'd1;
        default: cnt <= cnt;
      endcase
    end
  end

endmodule

// File: rtl/nibble_packer_4to16.sv
// Width up-converter: collects 4-bit symbols into 16-bit words and hands
// them downstream through a valid/ready handshake, with flush support for
// emitting a partially filled word together with a per-slot valid mask.
// Ports:
//   clk       - rising-edge clock
//   rstn      - synchronous active-low reset
//   din       - input symbol
//   din_en    - din valid
//   din_rdy   - symbol and/or flush can be accepted this cycle
//   flush     - emit any partial word (taken only with din_rdy)
//   dout      - packed word at the head of the output buffer
//   dout_mask - bit i set when dout[4i+3:4i] holds data
//   dout_en   - dout/dout_mask valid
//   dout_rdy  - downstream takes the word
module nibble_packer_4to16
  import nibble_packer_4to16_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter int OUT_DEPTH = BUF_DEPTH
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic [DATA_IN_WIDTH-1:0]  din,
  input  logic                      din_en,
  output logic                      din_rdy,
  input  logic                      flush,
  output logic [DATA_OUT_WIDTH-1:0] dout,
  output logic [RATIO-1:0]          dout_mask,
  output logic                      dout_en,
  input  logic                      dout_rdy
);

  slot_t                     acc_cnt;
  logic [DATA_OUT_WIDTH-1:0] acc;
  mask_t                     acc_mask;
  logic                      run_q;
  logic [1:0]                buf_cnt;
  word_t                     head;
  word_t                     push_word;
  slot_t                     slot;
  logic [DATA_OUT_WIDTH-1:0] next_acc;
  mask_t                     next_mask;
  logic                      nib_acc;
  logic                      flush_acc;
  logic                      word_full;
  logic                      push;
  logic                      pop;

  // Ready depends only on registered state: run_q keeps it low while in
  // reset, and a free buffer slot guarantees any completion can be pushed.
  assign din_rdy   = run_q && (buf_cnt != 2'(OUT_DEPTH));
  assign nib_acc   = din_en && din_rdy;
  assign flush_acc = flush && din_rdy;
  assign slot      = slot_index(MSB_FIRST, acc_cnt);
  assign word_full = nib_acc && (acc_cnt == slot_t'(RATIO - 1));

  // A flush with nothing held and no symbol arriving emits nothing, so an
  // all-zero mask never reaches the output.
  assign push = word_full || (flush_acc && (nib_acc || (acc_cnt != '0)));

  // Accumulator contents including this cycle's symbol; this is what gets
  // pushed, so a flush coinciding with a symbol carries that symbol along.
  always_comb begin
    next_acc  = acc;
    next_mask = acc_mask;
    if (nib_acc) begin
      next_acc[slot*DATA_IN_WIDTH +: DATA_IN_WIDTH] = din;
      next_mask[slot] = 1'b1;
    end
  end

  assign push_word = '{data: next_acc, mask: next_mask};

  // Accumulator state. A push always restarts from an empty word so that
  // unfilled slots of the next word read as zero.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      run_q    <= 1'b0;
      acc_cnt  <= '0;
      acc      <= '0;
      acc_mask <= '0;
    end else begin
      run_q <= 1'b1;
      if (push) begin
        acc_cnt  <= '0;
        acc      <= '0;
        acc_mask <= '0;
      end else if (nib_acc) begin
        acc_cnt  <= acc_cnt + slot_t'(1);
        acc      <= next_acc;
        acc_mask <= next_mask;
      end
    end
  end

  assign pop = dout_en && dout_rdy;

  pack_out_buf #(
    .WIDTH(WORD_WIDTH)
  ) u_buf (
    .clk      (clk),
    .rstn     (rstn),
    .push     (push),
    .push_data(push_word),
    .pop      (pop),
    .head     (head),
    .cnt      (buf_cnt)
  );

  assign dout_en   = (buf_cnt != 2'd0);
  assign dout      = head.data;
  assign dout_mask = head.mask;

endmodule

// File: tb/tb_nibble_packer_4to16.sv
// Self-checking bench for nibble_packer_4to16. Two instances (MSB-first and
// LSB-first) share one stimulus stream. A cycle model predicts ready, valid
// and the head word each cycle; completed words are queued when the model
// accepts stimulus and popped when the downstream takes them. Directed
// vectors and multi-cycle sequences compare captured output words against
// hand-derived constants.
module tb_nibble_packer_4to16;

  logic        clk;
  logic        rstn;
  logic [3:0]  din;
  logic        din_en;
  logic        flush;
  logic        dout_rdy;
  logic        din_rdy_m, din_rdy_l;
  logic        dout_en_m, dout_en_l;
  logic [15:0] dout_m, dout_l;
  logic [3:0]  mask_m, mask_l;

  int checks = 0;
  int errors = 0;

  // Expected word in arrival order: symbol k sits at nibs[4k+3:4k].
  typedef struct {
    logic [15:0] nibs;
    int          n;
  } exp_word_t;

  // Directed vector: symbols listed first-to-last from the top nibble,
  // flush_mode 0 = none, 1 = with last symbol, 2 = separate cycle.
  typedef struct {
    logic [15:0] nibs;
    int          n;
    int          flush_mode;
    int          exp_count;
    logic [15:0] exp_msb;
    logic [3:0]  exp_mask_msb;
    logic [15:0] exp_lsb;
    logic [3:0]  exp_mask_lsb;
  } vec_t;

  exp_word_t   exp_q[$];
  exp_word_t   cur;
  logic [19:0] cap_m[$];
  logic [19:0] cap_l[$];
  bit          m_run = 1'b0;
  vec_t        vecs[6];

  nibble_packer_4to16 #(.MSB_FIRST(1'b1), .OUT_DEPTH(2)) u_msb (
    .clk(clk), .rstn(rstn), .din(din), .din_en(din_en), .din_rdy(din_rdy_m),
    .flush(flush), .dout(dout_m), .dout_mask(mask_m), .dout_en(dout_en_m),
    .dout_rdy(dout_rdy)
  );

  nibble_packer_4to16 #(.MSB_FIRST(1'b0), .OUT_DEPTH(2)) u_lsb (
    .clk(clk), .rstn(rstn), .din(din), .din_en(din_en), .din_rdy(din_rdy_l),
    .flush(flush), .dout(dout_l), .dout_mask(mask_l), .dout_en(dout_en_l),
    .dout_rdy(dout_rdy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count a comparison and report it when the DUT value differs.
  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Packs a model word into {data, mask} for the given slot order.
  function automatic logic [19:0] modelWord(input exp_word_t e, input bit msb);
    logic [15:0] d;
    logic [3:0]  m;
    int          s;
    d = '0;
    m = '0;
    for (int k = 0; k < e.n; k++) begin
      s = msb ? (3 - k) : k;
      d[s*4 +: 4] = e.nibs[k*4 +: 4];
      m[s] = 1'b1;
    end
    return {d, m};
  endfunction

  // Drive one symbol/flush from just after a rising edge and hold it until
  // the DUT is ready at an edge; returns just after that edge.
  task automatic applyStimulus(input logic [3:0] nib, input logic en, input logic fl);
    int waited;
    waited = 0;
    din    = nib;
    din_en = en;
    flush  = fl;
    @(negedge clk);
    while (din_rdy_m !== 1'b1 && waited < 100) begin
      waited++;
      @(negedge clk);
    end
    if (waited >= 100) begin
      checks++;
      errors++;
      $display("[TB] FAIL handshake_timeout actual=din_rdy low required=din_rdy high");
    end
    @(posedge clk);
    #1;
    din_en = 1'b0;
    flush  = 1'b0;
  endtask

  // Scoreboard: on each falling edge compare outputs against the model
  // state, record words taken downstream, then advance the model across
  // the coming rising edge using the inputs now stable.
  always @(negedge clk) begin
    logic exp_rdy;
    logic [19:0] w;
    exp_rdy = m_run && (exp_q.size() != 2);
    checkOutput("din_rdy_msb", 32'(din_rdy_m), 32'(exp_rdy));
    checkOutput("din_rdy_lsb", 32'(din_rdy_l), 32'(exp_rdy));
    checkOutput("dout_en_msb", 32'(dout_en_m), 32'(exp_q.size() != 0));
    checkOutput("dout_en_lsb", 32'(dout_en_l), 32'(exp_q.size() != 0));
    if (exp_q.size() != 0) begin
      w = modelWord(exp_q[0], 1'b1);
      checkOutput("head_msb", 32'({dout_m, mask_m}), 32'(w));
      w = modelWord(exp_q[0], 1'b0);
      checkOutput("head_lsb", 32'({dout_l, mask_l}), 32'(w));
    end
    if (dout_en_m === 1'b1 && dout_rdy) cap_m.push_back({dout_m, mask_m});
    if (dout_en_l === 1'b1 && dout_rdy) cap_l.push_back({dout_l, mask_l});
    if (!rstn) begin
      m_run    = 1'b0;
      cur.n    = 0;
      cur.nibs = '0;
      exp_q.delete();
    end else begin
      if (exp_q.size() != 0 && dout_rdy) void'(exp_q.pop_front());
      if (din_en && exp_rdy) begin
        cur.nibs[cur.n*4 +: 4] = din;
        cur.n++;
      end
      if (cur.n == 4 || (flush && exp_rdy && cur.n != 0)) begin
        exp_q.push_back(cur);
        cur.n    = 0;
        cur.nibs = '0;
      end
      m_run = 1'b1;
    end
  end

  initial begin
    logic [3:0]  nb;
    logic [19:0] stall_m[3];
    logic [19:0] stall_l[3];
    bit          last_rdy;

    vecs[0] = '{16'hABCD, 4, 0, 1, 16'hABCD, 4'b1111, 16'hDCBA, 4'b1111};
    vecs[1] = '{16'h1200, 2, 2, 1, 16'h1200, 4'b1100, 16'h0021, 4'b0011};
    vecs[2] = '{16'h5678, 4, 1, 1, 16'h5678, 4'b1111, 16'h8765, 4'b1111};
    vecs[3] = '{16'h0000, 0, 2, 0, 16'h0000, 4'b0000, 16'h0000, 4'b0000};
    vecs[4] = '{16'h7000, 1, 1, 1, 16'h7000, 4'b1000, 16'h0007, 4'b0001};
    vecs[5] = '{16'h1230, 3, 1, 1, 16'h1230, 4'b1110, 16'h0321, 4'b0111};
    stall_m = '{{16'h0123, 4'hF}, {16'h4567, 4'hF}, {16'h89AB, 4'hF}};
    stall_l = '{{16'h3210, 4'hF}, {16'h7654, 4'hF}, {16'hBA98, 4'hF}};

    rstn     = 1'b0;
    din      = 4'h0;
    din_en   = 1'b0;
    flush    = 1'b0;
    dout_rdy = 1'b1;
    cur.n    = 0;
    cur.nibs = '0;

    // Reset state.
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_dout", 32'(dout_m), 32'h0);
    checkOutput("reset_mask", 32'(mask_m), 32'h0);
    checkOutput("reset_dout_en", 32'(dout_en_m), 32'h0);
    checkOutput("reset_din_rdy", 32'(din_rdy_m), 32'h0);
    @(posedge clk);
    #1 rstn = 1'b1;
    @(posedge clk);
    #1;
    checkOutput("release_din_rdy", 32'(din_rdy_m), 32'h1);

    // Directed vectors.
    for (int v = 0; v < 6; v++) begin
      cap_m.delete();
      cap_l.delete();
      for (int k = 0; k < vecs[v].n; k++) begin
        nb = vecs[v].nibs[15-4*k -: 4];
        applyStimulus(nb, 1'b1, (vecs[v].flush_mode == 1) && (k == vecs[v].n - 1));
      end
      if (vecs[v].flush_mode == 2) applyStimulus(4'h0, 1'b0, 1'b1);
      repeat (4) @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_count_msb", v), 32'(cap_m.size()), 32'(vecs[v].exp_count));
      checkOutput($sformatf("vec%0d_count_lsb", v), 32'(cap_l.size()), 32'(vecs[v].exp_count));
      if (vecs[v].exp_count == 1 && cap_m.size() > 0)
        checkOutput($sformatf("vec%0d_word_msb", v), 32'(cap_m[0]),
                    32'({vecs[v].exp_msb, vecs[v].exp_mask_msb}));
      if (vecs[v].exp_count == 1 && cap_l.size() > 0)
        checkOutput($sformatf("vec%0d_word_lsb", v), 32'(cap_l[0]),
                    32'({vecs[v].exp_lsb, vecs[v].exp_mask_lsb}));
    end

    // Stall: twelve symbols with the downstream blocked, then released.
    cap_m.delete();
    cap_l.delete();
    dout_rdy = 1'b0;
    fork
      begin
        for (int i = 0; i < 12; i++) applyStimulus(4'(i), 1'b1, 1'b0);
      end
      begin
        repeat (20) @(negedge clk);
        checkOutput("stall_din_rdy", 32'(din_rdy_m), 32'h0);
        checkOutput("stall_head", 32'({dout_m, mask_m}), 32'({16'h0123, 4'hF}));
        @(posedge clk);
        #1 dout_rdy = 1'b1;
      end
    join
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stall_count_msb", 32'(cap_m.size()), 32'd3);
    checkOutput("stall_count_lsb", 32'(cap_l.size()), 32'd3);
    for (int k = 0; k < 3; k++) begin
      if (k < cap_m.size()) checkOutput($sformatf("stall_word%0d_msb", k), 32'(cap_m[k]), 32'(stall_m[k]));
      if (k < cap_l.size()) checkOutput($sformatf("stall_word%0d_lsb", k), 32'(cap_l[k]), 32'(stall_l[k]));
    end

    // Reset in the middle of a word discards it.
    cap_m.delete();
    cap_l.delete();
    applyStimulus(4'h3, 1'b1, 1'b0);
    applyStimulus(4'h4, 1'b1, 1'b0);
    applyStimulus(4'h5, 1'b1, 1'b0);
    rstn = 1'b0;
    @(posedge clk);
    #1 rstn = 1'b1;
    @(negedge clk);
    checkOutput("midreset_dout_en", 32'(dout_en_m), 32'h0);
    checkOutput("midreset_din_rdy", 32'(din_rdy_m), 32'h0);
    @(posedge clk);
    #1;
    applyStimulus(4'h9, 1'b1, 1'b0);
    applyStimulus(4'hA, 1'b1, 1'b0);
    applyStimulus(4'hB, 1'b1, 1'b0);
    applyStimulus(4'hC, 1'b1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    checkOutput("midreset_count", 32'(cap_m.size()), 32'd1);
    if (cap_m.size() > 0) checkOutput("midreset_word_msb", 32'(cap_m[0]), 32'({16'h9ABC, 4'hF}));
    if (cap_l.size() > 0) checkOutput("midreset_word_lsb", 32'(cap_l[0]), 32'({16'hCBA9, 4'hF}));

    // Random traffic against the scoreboard; a refused request is held.
    last_rdy = 1'b1;
    for (int c = 0; c < 10000; c++) begin
      if (!((din_en || flush) && !last_rdy)) begin
        din    = 4'($urandom_range(0, 15));
        din_en = ($urandom_range(0, 3) != 0);
        flush  = ($urandom_range(0, 7) == 0);
      end
      dout_rdy = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      last_rdy = din_rdy_m;
      @(posedge clk);
      #1;
    end
    din_en   = 1'b0;
    flush    = 1'b0;
    dout_rdy = 1'b1;
    applyStimulus(4'h0, 1'b0, 1'b1);
    repeat (6) @(posedge clk);
    #1;
    checkOutput("drain_dout_en", 32'(dout_en_m), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
